// File: rtl/acc_load_unit_if.sv
// Load-command, data-memory read and accumulator write signals of acc_load_unit.
// The master modport is the load unit itself; slave is the CPU/memory/accumulator side.
interface acc_load_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              ld_start;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              acc_enable;
    logic [DATA_W-1:0] acc_data;

    modport master (
        input  ld_start, ld_addr, mem_ready, mem_rdata,
        output ld_busy, ld_done, ld_err, mem_req, mem_addr, acc_enable, acc_data
    );

    modport slave (
        output ld_start, ld_addr, mem_ready, mem_rdata,
        input  ld_busy, ld_done, ld_err, mem_req, mem_addr, acc_enable, acc_data
    );
endinterface

// File: rtl/acc_load_unit.sv
// Memory-to-accumulator load sequencer: IDLE -> REQ (wait for mem_ready) -> WRITE.
// Optional REQ timeout with sticky ld_err is enabled by defining LOAD_TIMEOUT_EN.
module acc_load_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            reset,
    acc_load_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ld_busy;
    logic              r_ld_done;
    logic              r_mem_req;
    logic              r_acc_enable;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_acc_data;

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ld_err;
`endif

    // NOTE: every output is a register updated with non-blocking assignments in this
    // one clocked block, so all outputs change together right after the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ld_busy    <= 1'b0;
            r_ld_done    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_acc_enable <= 1'b0;
            r_mem_addr   <= '0;
            r_acc_data   <= '0;
`ifdef LOAD_TIMEOUT_EN
            r_cnt        <= '0;
            r_ld_err     <= 1'b0;
`endif
        end else begin
            r_ld_done    <= 1'b0;
            r_acc_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.ld_start) begin
                        r_mem_addr <= bus.ld_addr;
                        r_mem_req  <= 1'b1;
                        r_ld_busy  <= 1'b1;
                        r_state    <= REQ;
`ifdef LOAD_TIMEOUT_EN
                        r_cnt      <= '0;
                        r_ld_err   <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        r_acc_data   <= bus.mem_rdata;
                        r_mem_req    <= 1'b0;
                        r_acc_enable <= 1'b1;
                        r_ld_done    <= 1'b1;
                        r_state      <= WRITE;
`ifdef LOAD_TIMEOUT_EN
                    // Abort on the cycle whose increment would bring the count to TIMEOUT.
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_mem_req <= 1'b0;
                        r_ld_busy <= 1'b0;
                        r_ld_err  <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                WRITE: begin
                    r_ld_busy <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_ld_busy <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ld_busy    = r_ld_busy;
    assign bus.ld_done    = r_ld_done;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.acc_enable = r_acc_enable;
    assign bus.acc_data   = r_acc_data;
`ifdef LOAD_TIMEOUT_EN
    assign bus.ld_err     = r_ld_err;
`else
    assign bus.ld_err     = 1'b0;
`endif
endmodule

// File: tb/tb_acc_load_unit.sv
// Self-checking bench for acc_load_unit: vector table of loads, scoreboard of expected
// accumulator writes, plus hand sequences for reset, back-to-back and timeout cases.
module tb_acc_load_unit;
`ifdef LOAD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          waits;
        bit          poke;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   n_pulse = 0;
    int   cyc     = 0;
    exp_t sb[$];
    int   done_q[$];
    vec_t vecs[6];

    acc_load_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    acc_load_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accumulator write must match the oldest outstanding load.
    always @(negedge clk) begin
        exp_t e;
        if (bus.acc_enable === 1'b1) begin
            n_pulse++;
            done_q.push_back(cyc);
            check("sb_done_with_enable", 32'(bus.ld_done), 32'd1);
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected_write: got acc_enable with acc_data=%h, expected none", bus.acc_data);
            end else begin
                e = sb.pop_front();
                check("sb_acc_data", 32'(bus.acc_data), 32'(e.data));
                check("sb_mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] addr, input logic [15:0] data,
                           input int waits, input bit poke);
        int p0;
        p0 = n_pulse;
        sb.push_back('{addr: addr, data: data});
        bus.ld_start = 1'b1;
        bus.ld_addr  = addr;
        bus.mem_ready = (waits == 0);
        bus.mem_rdata = (waits == 0) ? data : 16'hDEAD;
        tick();
        if (poke) bus.ld_addr = 16'h1234;
        else      bus.ld_start = 1'b0;
        check("req_first_cycle", 32'(bus.mem_req), 32'd1);
        check("busy_first_cycle", 32'(bus.ld_busy), 32'd1);
        check("mem_addr_latched", 32'(bus.mem_addr), 32'(addr));
        check("err_cleared", 32'(bus.ld_err), 32'd0);
        for (int i = 0; i < waits; i++) begin
            if (i == waits - 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = data;
            end
            tick();
            if (i != waits - 1) begin
                check("req_held", 32'(bus.mem_req), 32'd1);
                check("no_early_write", 32'(bus.acc_enable), 32'd0);
                check("err_while_wait", 32'(bus.ld_err), 32'd0);
            end
        end
        if (waits == 0) tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = ~data;
        check("write_enable", 32'(bus.acc_enable), 32'd1);
        check("write_done", 32'(bus.ld_done), 32'd1);
        check("write_data", 32'(bus.acc_data), 32'(data));
        check("write_req_low", 32'(bus.mem_req), 32'd0);
        check("write_busy", 32'(bus.ld_busy), 32'd1);
        tick();
        bus.ld_start = 1'b0;
        check("idle_enable_low", 32'(bus.acc_enable), 32'd0);
        check("idle_done_low", 32'(bus.ld_done), 32'd0);
        check("idle_busy_low", 32'(bus.ld_busy), 32'd0);
        check("idle_addr_held", 32'(bus.mem_addr), 32'(addr));
        check("idle_data_held", 32'(bus.acc_data), 32'(data));
        check("one_pulse", 32'(n_pulse - p0), 32'd1);
    endtask

    initial begin
        vecs[0] = '{addr: 16'h0040, data: 16'hAAAA, waits: 0, poke: 1'b0};
        vecs[1] = '{addr: 16'h0100, data: 16'hF0F0, waits: 4, poke: 1'b0};
        vecs[2] = '{addr: 16'h0200, data: 16'h5A5A, waits: 2, poke: 1'b1};
        vecs[3] = '{addr: 16'hFFFF, data: 16'hFFFF, waits: 1, poke: 1'b0};
        vecs[4] = '{addr: 16'h8001, data: 16'h8001, waits: 7, poke: 1'b1};
        vecs[5] = '{addr: 16'h0000, data: 16'h0000, waits: 0, poke: 1'b1};

        reset         = 1'b0;
        bus.ld_start  = 1'b0;
        bus.ld_addr   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.ld_busy), 32'd0);
        check("rst_done", 32'(bus.ld_done), 32'd0);
        check("rst_err", 32'(bus.ld_err), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_enable", 32'(bus.acc_enable), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_data", 32'(bus.acc_data), 32'd0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) do_load(vecs[v].addr, vecs[v].data, vecs[v].waits, vecs[v].poke);

        // Back-to-back: second start on the first IDLE cycle after completion.
        done_q.delete();
        do_load(16'h0040, 16'hAAAA, 0, 1'b0);
        do_load(16'h0002, 16'h0F0F, 0, 1'b0);
        check("b2b_pulse_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) check("b2b_spacing", 32'(done_q[1] - done_q[0]), 32'd3);

        // Mid-load reset in REQ: outputs clear asynchronously, no write afterwards.
        bus.ld_start = 1'b1;
        bus.ld_addr  = 16'h0BAD;
        tick();
        bus.ld_start = 1'b0;
        tick();
        #3 reset = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.ld_busy), 32'd0);
        check("mrst_req", 32'(bus.mem_req), 32'd0);
        check("mrst_addr", 32'(bus.mem_addr), 32'd0);
        check("mrst_data", 32'(bus.acc_data), 32'd0);
        check("mrst_enable", 32'(bus.acc_enable), 32'd0);
        tick();
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_write", 32'(bus.acc_enable), 32'd0);
            check("mrst_idle", 32'(bus.ld_busy), 32'd0);
            check("mrst_data_zero", 32'(bus.acc_data), 32'd0);
        end
        bus.mem_ready = 1'b0;

`ifdef LOAD_TIMEOUT_EN
        do_load(16'h0300, 16'h1357, 0, 1'b0);
        bus.ld_start = 1'b1;
        bus.ld_addr  = 16'h0400;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            check("to_req_held", 32'(bus.mem_req), 32'd1);
            check("to_err_low", 32'(bus.ld_err), 32'd0);
            tick();
        end
        check("to_last_req", 32'(bus.mem_req), 32'd1);
        tick();
        check("to_err_set", 32'(bus.ld_err), 32'd1);
        check("to_req_drop", 32'(bus.mem_req), 32'd0);
        check("to_busy_drop", 32'(bus.ld_busy), 32'd0);
        check("to_no_write", 32'(bus.acc_enable), 32'd0);
        check("to_data_kept", 32'(bus.acc_data), 32'h1357);
        tick();
        check("to_err_sticky", 32'(bus.ld_err), 32'd1);
        do_load(16'h0500, 16'h2468, 1, 1'b0);
`else
        // Without the timeout option REQ waits indefinitely and ld_err stays low.
        do_load(16'h3000, 16'hC3C3, 300, 1'b0);
`endif

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
